axil_read_router: RTL and testbench
===================================

// Module: axil_read_router
// PURPOSE
//  Single-master to N-slave AXI-Lite read-channel router/controller.
//  Decodes each AR address against per-slave windows and forwards it to the selected slave.
//  Steers that slave's R beat back to the master; one transaction in flight at a time.
//  Unmapped addresses are answered locally with DECERR. Sits between the master port and the slave fabric.
// PARAMETERS
//  N          4                                  number of slave ports (>=1)
//  ADDR_WIDTH 32                                 address width
//  DATA_WIDTH 32                                 read data width
//  BASE_ADDR  {32'h3000,32'h2000,32'h1000,32'h0} packed N*ADDR_WIDTH; slice i = base of slave i
//  SIZE       {4{32'h1000}}                      packed N*ADDR_WIDTH; slice i = window bytes of slave i (0 = disabled)
// PORTS
//  clk         in   1              clock; all logic on rising edge
//  rst         in   1              synchronous reset, active-high
//  s_araddr    in   ADDR_WIDTH     master AR address
//  s_arvalid   in   1              master AR valid
//  s_arready   out  1              master AR ready
//  s_rdata     out  DATA_WIDTH     master R data
//  s_rresp     out  2              master R response
//  s_rvalid    out  1              master R valid
//  s_rready    in   1              master R ready
//  m_araddr    out  ADDR_WIDTH     AR address, broadcast to all slaves
//  m_arvalid   out  N              per-slave AR valid
//  m_arready   in   N              per-slave AR ready
//  m_rdata     in   N*DATA_WIDTH   per-slave R data; slice i
//  m_rresp     in   2*N            per-slave R response; slice i
//  m_rvalid    in   N              per-slave R valid
//  m_rready    out  N              per-slave R ready
//  busy        out  1              1 when state != IDLE
//  decerr_cnt  out  16             saturating count of DECERR responses
// BEHAVIOUR
//  Reset values:
//   - state IDLE; m_arvalid=0, m_rready=0, s_rvalid=0; m_araddr=0, s_rdata=0, s_rresp=0.
//   - busy=0, decerr_cnt=0; s_arready=0 while rst=1.
//  Decode (combinational on s_araddr):
//   - Slave i hits if s_araddr>=base_i && (s_araddr-base_i)<size_i.
//   - Subtraction is done in ADDR_WIDTH bits, so no overflow at the top of the address space.
//   - On overlapping windows, the lowest index wins. No hit = miss.
//  FSM:
//   - IDLE: s_arready=1.
//     On s_arvalid&&s_arready: register addr into m_araddr and the selected index into sel.
//     Hit -> ADDR; miss -> ERR.
//   - ADDR: m_arvalid[sel]=1, all other bits 0.
//     On m_arready[sel] -> DATA. m_arvalid is never withdrawn before its handshake.
//   - DATA: combinational passthrough:
//     s_rvalid=m_rvalid[sel], s_rdata/s_rresp = slice sel, m_rready[sel]=s_rready, other m_rready=0.
//     On m_rvalid[sel]&&s_rready -> IDLE.
//   - ERR: s_rvalid=1 (registered), s_rdata=0, s_rresp=2'b11.
//     On s_rready -> IDLE; decerr_cnt+=1 on that handshake, saturating at 16'hFFFF.
//  Latency:
//   - AR accepted at edge T -> m_arvalid[sel] high in cycle T+1 (hit).
//   - AR accepted at edge T -> s_rvalid high in cycle T+1 (miss).
//  Handshake rules:
//   - s_arready=0 outside IDLE, so a new AR is accepted only in the cycle after R completes.
//   - s_rvalid, s_rdata and s_rresp stay stable while s_rready=0.
//   - Responses from non-selected slaves are ignored; their m_rready stays 0.
//   - At most one m_arvalid bit is high at any time.
//  Reset mid-operation: rst=1 in any state -> IDLE and all reset values on the next edge.
//   - The outstanding slave transaction is abandoned; the system resets slaves together with this block.
// TESTING
//  1 Reset: hold rst 2 cycles, release -> s_arready=1, all valids 0, busy=0, decerr_cnt=0.
//  2 Hit: araddr=0x2004; slave2 arready after 3 cycles; rdata=0xDEADBEEF, rresp=00
//    -> m_arvalid=4'b0100 from T+1 until handshake; s_rdata=0xDEADBEEF, s_rresp=00.
//  3 Miss: araddr=0x9000 -> m_arvalid stays 0; s_rvalid at T+1, rresp=11, rdata=0; decerr_cnt 0->1.
//  4 Backpressure: s_rready=0 for 5 cycles in DATA -> s_rvalid and data held, m_rready[sel]=0;
//    s_arvalid with new addr not accepted until R completes.
//  5 Boundaries: 0x2FFF->slave2, 0x3000->slave3, 0x4000->DECERR.
//    Override slave3 base=0xFFFFF000: 0xFFFFFFFF->slave3 (no wrap).
//  6 Reset in DATA: rst at cycle of slave rvalid -> next cycle IDLE, s_rvalid=0, m_rready=0;
//    a fresh read then completes normally.

Source files
------------

// File: rtl/axil_read_router.sv
// AXI-Lite read-channel router: one master, N address-decoded slaves.
// One transaction in flight; unmapped reads are answered locally with DECERR.
module axil_read_router #(
    parameter int N          = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [N*ADDR_WIDTH-1:0] BASE_ADDR =
        {32'h3000, 32'h2000, 32'h1000, 32'h0},
    parameter logic [N*ADDR_WIDTH-1:0] SIZE = {4{32'h1000}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [N-1:0]            m_arvalid,
    input  logic [N-1:0]            m_arready,
    input  logic [N*DATA_WIDTH-1:0] m_rdata,
    input  logic [2*N-1:0]          m_rresp,
    input  logic [N-1:0]            m_rvalid,
    output logic [N-1:0]            m_rready,
    output logic                    busy,
    output logic [15:0]             decerr_cnt
);

    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        ERR
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           cnt_q, cnt_d;

    logic                  hit;
    logic [SEL_W-1:0]      hit_idx;
    logic [ADDR_WIDTH-1:0] base_v;
    logic [ADDR_WIDTH-1:0] size_v;
    logic [ADDR_WIDTH-1:0] off_v;

    // Window decode; scanning downward lets the lowest matching index win.
    // The offset is taken modulo 2^ADDR_WIDTH so a top-of-space window never wraps.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        base_v  = '0;
        size_v  = '0;
        off_v   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            base_v = BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
            size_v = SIZE[i*ADDR_WIDTH +: ADDR_WIDTH];
            off_v  = s_araddr - base_v;
            if (s_araddr >= base_v && off_v < size_v) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    // Next-state and channel steering; R path is a pure passthrough in DATA.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        m_arvalid = '0;
        m_rready  = '0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rresp   = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (s_arvalid) begin
                    addr_d  = s_araddr;
                    sel_d   = hit_idx;
                    state_d = hit ? ADDR : ERR;
                end
            end
            ADDR: begin
                m_arvalid[sel_q] = 1'b1;
                if (m_arready[sel_q]) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                s_rvalid        = m_rvalid[sel_q];
                s_rdata         = m_rdata[sel_q*DATA_WIDTH +: DATA_WIDTH];
                s_rresp         = m_rresp[sel_q*2 +: 2];
                m_rready[sel_q] = s_rready;
                if (m_rvalid[sel_q] && s_rready) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                s_rvalid = 1'b1;
                s_rresp  = 2'b11;
                if (s_rready) begin
                    state_d = IDLE;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and DECERR counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_arready  = (state_q == IDLE) && !rst;
    assign m_araddr   = addr_q;
    assign busy       = (state_q != IDLE);
    assign decerr_cnt = cnt_q;

endmodule

// File: tb/tb_axil_read_router.sv
// Directed bench for axil_read_router; a second instance relocates
// slave 3 to the top of the address space to exercise the no-wrap decode.
module tb_axil_read_router;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  s_araddr;
    logic         s_arvalid;
    logic         s_rready;
    logic [3:0]   m_arready;
    logic [127:0] m_rdata;
    logic [7:0]   m_rresp;
    logic [3:0]   m_rvalid;

    logic         s_arready, s_rvalid, busy;
    logic [31:0]  s_rdata, m_araddr;
    logic [1:0]   s_rresp;
    logic [3:0]   m_arvalid, m_rready;
    logic [15:0]  decerr_cnt;

    logic         d2_s_arready, d2_s_rvalid, d2_busy;
    logic [31:0]  d2_s_rdata, d2_m_araddr;
    logic [1:0]   d2_s_rresp;
    logic [3:0]   d2_m_arvalid, d2_m_rready;
    logic [15:0]  d2_decerr_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axil_read_router dut (
        .clk(clk), .rst(rst),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
        .s_rready(s_rready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .busy(busy), .decerr_cnt(decerr_cnt)
    );

    axil_read_router #(
        .BASE_ADDR({32'hFFFFF000, 32'h2000, 32'h1000, 32'h0})
    ) dut2 (
        .clk(clk), .rst(rst),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(d2_s_arready),
        .s_rdata(d2_s_rdata), .s_rresp(d2_s_rresp), .s_rvalid(d2_s_rvalid),
        .s_rready(s_rready),
        .m_araddr(d2_m_araddr), .m_arvalid(d2_m_arvalid),
        .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid),
        .m_rready(d2_m_rready),
        .busy(d2_busy), .decerr_cnt(d2_decerr_cnt)
    );

    // Full read from IDLE; idx < 0 means the address is expected to miss in dut.
    task automatic run_read(input logic [31:0] addr, input int idx,
                            input logic [31:0] data, input logic [1:0] resp,
                            output logic [3:0] arv, output logic [3:0] arv2,
                            output logic [31:0] rd, output logic [1:0] rr,
                            output logic [31:0] rd2);
        s_araddr  = addr;
        s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        arv  = m_arvalid;
        arv2 = d2_m_arvalid;
        if (idx >= 0) begin
            m_arready = 4'b0001 << idx;
            @(posedge clk); #1;
            m_arready = 4'b0000;
            m_rdata[idx*32 +: 32] = data;
            m_rresp[idx*2 +: 2]   = resp;
            m_rvalid = 4'b0001 << idx;
        end
        s_rready = 1'b1;
        #1;
        rd  = s_rdata;
        rr  = s_rresp;
        rd2 = d2_s_rdata;
        @(posedge clk); #1;
        s_rready = 1'b0;
        m_rvalid = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (s_arready !== 1'b0) begin
            fails++;
            $display("FAIL reset_arready_in_rst: got %b expected 0", s_arready);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (s_arready !== 1'b1) begin
            fails++;
            $display("FAIL reset_arready: got %b expected 1", s_arready);
        end
        tests++;
        if ({m_arvalid, m_rready, s_rvalid, busy} !== 10'b0) begin
            fails++;
            $display("FAIL reset_valids: got %b expected 0",
                     {m_arvalid, m_rready, s_rvalid, busy});
        end
        tests++;
        if (decerr_cnt !== 16'd0 || m_araddr !== 32'd0 ||
            s_rdata !== 32'd0 || s_rresp !== 2'b00) begin
            fails++;
            $display("FAIL reset_regs: got cnt=%h addr=%h rdata=%h resp=%b expected 0",
                     decerr_cnt, m_araddr, s_rdata, s_rresp);
        end
    endtask

    task automatic test_hit();
        s_araddr  = 32'h2004;
        s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        tests++;
        if (m_arvalid !== 4'b0100 || m_araddr !== 32'h2004) begin
            fails++;
            $display("FAIL hit_ar_t1: got arvalid=%b addr=%h expected 0100 00002004",
                     m_arvalid, m_araddr);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            tests++;
            if (m_arvalid !== 4'b0100 || s_arready !== 1'b0) begin
                fails++;
                $display("FAIL hit_ar_hold%0d: got arvalid=%b arready=%b expected 0100 0",
                         c, m_arvalid, s_arready);
            end
        end
        m_arready = 4'b0100;
        @(posedge clk); #1;
        m_arready = 4'b0000;
        tests++;
        if (m_arvalid !== 4'b0000) begin
            fails++;
            $display("FAIL hit_ar_drop: got %b expected 0000", m_arvalid);
        end
        m_rdata[2*32 +: 32] = 32'hDEADBEEF;
        m_rresp[2*2 +: 2]   = 2'b00;
        m_rdata[1*32 +: 32] = 32'h11111111;
        m_rresp[1*2 +: 2]   = 2'b10;
        m_rvalid = 4'b0110;
        s_rready = 1'b1;
        #1;
        tests++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'hDEADBEEF || s_rresp !== 2'b00) begin
            fails++;
            $display("FAIL hit_r: got v=%b d=%h r=%b expected 1 deadbeef 00",
                     s_rvalid, s_rdata, s_rresp);
        end
        tests++;
        if (m_rready !== 4'b0100) begin
            fails++;
            $display("FAIL hit_rready: got %b expected 0100", m_rready);
        end
        @(posedge clk); #1;
        s_rready = 1'b0;
        m_rvalid = 4'b0000;
        tests++;
        if (busy !== 1'b0 || s_arready !== 1'b1) begin
            fails++;
            $display("FAIL hit_done: got busy=%b arready=%b expected 0 1",
                     busy, s_arready);
        end
    endtask

    task automatic test_miss();
        s_araddr  = 32'h9000;
        s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        tests++;
        if (m_arvalid !== 4'b0000 || s_rvalid !== 1'b1 ||
            s_rresp !== 2'b11 || s_rdata !== 32'd0) begin
            fails++;
            $display("FAIL miss_r: got arv=%b v=%b r=%b d=%h expected 0000 1 11 0",
                     m_arvalid, s_rvalid, s_rresp, s_rdata);
        end
        @(posedge clk); #1;
        tests++;
        if (s_rvalid !== 1'b1 || s_rresp !== 2'b11 || decerr_cnt !== 16'd0) begin
            fails++;
            $display("FAIL miss_hold: got v=%b r=%b cnt=%0d expected 1 11 0",
                     s_rvalid, s_rresp, decerr_cnt);
        end
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
        tests++;
        if (decerr_cnt !== 16'd1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL miss_cnt: got cnt=%0d busy=%b expected 1 0",
                     decerr_cnt, busy);
        end
    endtask

    task automatic test_backpressure();
        s_araddr  = 32'h1010;
        s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        m_arready = 4'b0010;
        @(posedge clk); #1;
        m_arready = 4'b0000;
        m_rdata[1*32 +: 32] = 32'hCAFE0001;
        m_rresp[1*2 +: 2]   = 2'b01;
        m_rvalid  = 4'b0010;
        s_rready  = 1'b0;
        s_araddr  = 32'h3000;
        s_arvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++;
            if (s_rvalid !== 1'b1 || s_rdata !== 32'hCAFE0001 ||
                s_rresp !== 2'b01 || m_rready !== 4'b0000) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b d=%h r=%b rr=%b expected 1 cafe0001 01 0000",
                         c, s_rvalid, s_rdata, s_rresp, m_rready);
            end
            tests++;
            if (s_arready !== 1'b0 || m_araddr !== 32'h1010) begin
                fails++;
                $display("FAIL bp_noaccept%0d: got arready=%b addr=%h expected 0 00001010",
                         c, s_arready, m_araddr);
            end
            @(posedge clk);
        end
        #1;
        s_rready = 1'b1;
        #1;
        tests++;
        if (m_rready !== 4'b0010) begin
            fails++;
            $display("FAIL bp_rready: got %b expected 0010", m_rready);
        end
        @(posedge clk); #1;
        s_rready = 1'b0;
        m_rvalid = 4'b0000;
        tests++;
        if (s_arready !== 1'b1) begin
            fails++;
            $display("FAIL bp_idle_after_r: got %b expected 1", s_arready);
        end
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        tests++;
        if (m_arvalid !== 4'b1000 || m_araddr !== 32'h3000) begin
            fails++;
            $display("FAIL bp_next_ar: got arv=%b addr=%h expected 1000 00003000",
                     m_arvalid, m_araddr);
        end
        m_arready = 4'b1000;
        @(posedge clk); #1;
        m_arready = 4'b0000;
        m_rdata[3*32 +: 32] = 32'h33330000;
        m_rresp[3*2 +: 2]   = 2'b00;
        m_rvalid = 4'b1000;
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
        m_rvalid = 4'b0000;
    endtask

    task automatic test_boundaries();
        logic [3:0]  arv, arv2;
        logic [31:0] rd, rd2;
        logic [1:0]  rr;
        run_read(32'h2FFF, 2, 32'h22222FFF, 2'b00, arv, arv2, rd, rr, rd2);
        tests++;
        if (arv !== 4'b0100 || rd !== 32'h22222FFF) begin
            fails++;
            $display("FAIL bnd_2fff: got arv=%b d=%h expected 0100 22222fff", arv, rd);
        end
        run_read(32'h3000, 3, 32'h33333000, 2'b00, arv, arv2, rd, rr, rd2);
        tests++;
        if (arv !== 4'b1000 || rd !== 32'h33333000) begin
            fails++;
            $display("FAIL bnd_3000: got arv=%b d=%h expected 1000 33333000", arv, rd);
        end
        run_read(32'h4000, -1, 32'h0, 2'b00, arv, arv2, rd, rr, rd2);
        tests++;
        if (arv !== 4'b0000 || rr !== 2'b11 || rd !== 32'd0 ||
            decerr_cnt !== 16'd2) begin
            fails++;
            $display("FAIL bnd_4000: got arv=%b r=%b d=%h cnt=%0d expected 0000 11 0 2",
                     arv, rr, rd, decerr_cnt);
        end
        run_read(32'hFFFFFFFF, 3, 32'hFFFF0003, 2'b00, arv, arv2, rd, rr, rd2);
        tests++;
        if (arv2 !== 4'b1000 || rd2 !== 32'hFFFF0003) begin
            fails++;
            $display("FAIL bnd_top: got arv=%b d=%h expected 1000 ffff0003", arv2, rd2);
        end
        tests++;
        if (arv !== 4'b0000 || rr !== 2'b11) begin
            fails++;
            $display("FAIL bnd_top_default_miss: got arv=%b r=%b expected 0000 11", arv, rr);
        end
    endtask

    task automatic test_reset_in_data();
        logic [3:0]  arv, arv2;
        logic [31:0] rd, rd2;
        logic [1:0]  rr;
        s_araddr  = 32'h0008;
        s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        m_arready = 4'b0001;
        @(posedge clk); #1;
        m_arready = 4'b0000;
        m_rdata[0 +: 32] = 32'hBAD0BAD0;
        m_rvalid = 4'b0001;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        m_rvalid = 4'b0000;
        #1;
        tests++;
        if (busy !== 1'b0 || s_rvalid !== 1'b0 || m_rready !== 4'b0000 ||
            s_arready !== 1'b1) begin
            fails++;
            $display("FAIL rstdata_idle: got busy=%b v=%b rr=%b arready=%b expected 0 0 0000 1",
                     busy, s_rvalid, m_rready, s_arready);
        end
        tests++;
        if (decerr_cnt !== 16'd0 || m_araddr !== 32'd0) begin
            fails++;
            $display("FAIL rstdata_regs: got cnt=%0d addr=%h expected 0 0",
                     decerr_cnt, m_araddr);
        end
        run_read(32'h0040, 0, 32'h12345678, 2'b00, arv, arv2, rd, rr, rd2);
        tests++;
        if (arv !== 4'b0001 || rd !== 32'h12345678 || rr !== 2'b00 ||
            busy !== 1'b0) begin
            fails++;
            $display("FAIL rstdata_fresh: got arv=%b d=%h r=%b busy=%b expected 0001 12345678 00 0",
                     arv, rd, rr, busy);
        end
    endtask

    initial begin
        rst       = 1'b1;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_arready = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rvalid  = '0;
        test_reset();
        test_hit();
        test_miss();
        test_backpressure();
        test_boundaries();
        test_reset_in_data();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
